iob_assim_fifo_ctrl: RTL and testbench



---
 rtl/iob_assim_fifo_ctrl.sv | 103 ++++++++++
 tb/tb_iob_assim_fifo_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/iob_assim_fifo_ctrl.sv
// Pointer/level controller that turns a wide-write, narrow-read RAM into a width-down-converting FIFO.
// Optional sticky error flags are enabled by defining IOB_ASSIM_FIFO_ERR_EN.
module iob_assim_fifo_ctrl #(
  parameter int W_DATA_W = 16,
  parameter int R_DATA_W = 8,
  parameter int W_ADDR_W = 6,
  parameter int R_ADDR_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [W_DATA_W-1:0] push_data,
  output logic                full,
  input  logic                pop,
  output logic [R_DATA_W-1:0] pop_data,
  output logic                pop_valid,
  output logic                empty,
  output logic [R_ADDR_W:0]   level,
  output logic                err_ovf,
  output logic                err_udf,
  output logic                mem_w_en,
  output logic                mem_w_port_en,
  output logic [W_ADDR_W-1:0] mem_w_addr,
  output logic [W_DATA_W-1:0] mem_data_in,
  output logic                mem_r_port_en,
  output logic [R_ADDR_W-1:0] mem_r_addr,
  input  logic [R_DATA_W-1:0] mem_data_out
);

  localparam int RATIO = W_DATA_W / R_DATA_W;
  localparam int LVL_W = R_ADDR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH       = LVL_W'(1 << R_ADDR_W);
  localparam logic [LVL_W-1:0] RATIO_LVL   = LVL_W'(RATIO);
  localparam logic [LVL_W-1:0] FULL_THRESH = DEPTH - RATIO_LVL;

  logic [W_ADDR_W-1:0] w_ptr;
  logic [R_ADDR_W-1:0] r_ptr;
  logic [LVL_W-1:0]    level_q;
  logic [LVL_W-1:0]    level_nxt;
  logic                pop_valid_q;
  logic                push_acc;
  logic                pop_acc;

  // Full blocks any push that would not fit a whole wide word.
  assign full  = (level_q > FULL_THRESH);
  assign empty = (level_q == '0);
  assign level = level_q;

  assign push_acc = rst_n & push & ~full;
  assign pop_acc  = rst_n & pop & ~empty;

  assign mem_w_en      = push_acc;
  assign mem_w_port_en = push_acc;
  assign mem_w_addr    = w_ptr;
  assign mem_data_in   = push_data;
  assign mem_r_port_en = pop_acc;
  assign mem_r_addr    = r_ptr;

  assign pop_data  = mem_data_out;
  assign pop_valid = pop_valid_q;

  always_comb begin
    level_nxt = level_q;
    if (push_acc) level_nxt = level_nxt + RATIO_LVL;
    if (pop_acc)  level_nxt = level_nxt - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      level_q     <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      if (push_acc) w_ptr <= w_ptr + W_ADDR_W'(1);
      if (pop_acc)  r_ptr <= r_ptr + R_ADDR_W'(1);
      level_q     <= level_nxt;
      pop_valid_q <= pop_acc;
    end
  end

`ifdef IOB_ASSIM_FIFO_ERR_EN
  logic err_ovf_q;
  logic err_udf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      if (push && full)  err_ovf_q <= 1'b1;
      if (pop  && empty) err_udf_q <= 1'b1;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_iob_assim_fifo_ctrl.sv
// Self-checking bench for iob_assim_fifo_ctrl with a behavioural asymmetric RAM model.
module tb_iob_assim_fifo_ctrl;

`ifdef IOB_ASSIM_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, push, pop;
  logic [15:0] push_data;
  logic        full, pop_valid, empty, err_ovf, err_udf;
  logic [7:0]  pop_data;
  logic [7:0]  level;
  logic        mem_w_en, mem_w_port_en, mem_r_port_en;
  logic [5:0]  mem_w_addr;
  logic [15:0] mem_data_in;
  logic [6:0]  mem_r_addr;
  logic [7:0]  mem_data_out;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  iob_assim_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .full(full),
    .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .empty(empty), .level(level),
    .err_ovf(err_ovf), .err_udf(err_udf), .mem_w_en(mem_w_en), .mem_w_port_en(mem_w_port_en),
    .mem_w_addr(mem_w_addr), .mem_data_in(mem_data_in), .mem_r_port_en(mem_r_port_en),
    .mem_r_addr(mem_r_addr), .mem_data_out(mem_data_out)
  );

  // Asymmetric RAM: 16-bit writes, registered 8-bit reads, low byte at even narrow address.
  logic [15:0] ram [64];
  always @(posedge clk) begin
    if (mem_w_en && mem_w_port_en) ram[mem_w_addr] <= mem_data_in;
    if (mem_r_port_en) begin
      if (mem_r_addr[0]) mem_data_out <= ram[mem_r_addr[6:1]][15:8];
      else               mem_data_out <= ram[mem_r_addr[6:1]][7:0];
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n, push, pop;
    logic [15:0] data;
    logic        exp_w_en, exp_r_en;
    logic [7:0]  exp_level;
    logic        exp_empty, exp_full, exp_pv, chk_data;
    logic [7:0]  exp_data;
    logic        exp_udf;
  } vec_t;

  vec_t vecs[11];

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n; push = v.push; pop = v.pop; push_data = v.data;
    #1;
    chk("vec_w_en", 16'(mem_w_en), 16'(v.exp_w_en));
    chk("vec_w_port_en", 16'(mem_w_port_en), 16'(v.exp_w_en));
    chk("vec_r_en", 16'(mem_r_port_en), 16'(v.exp_r_en));
  endtask

  task automatic checkOutput(input vec_t v);
    chk("vec_level", 16'(level), 16'(v.exp_level));
    chk("vec_empty", 16'(empty), 16'(v.exp_empty));
    chk("vec_full", 16'(full), 16'(v.exp_full));
    chk("vec_pop_valid", 16'(pop_valid), 16'(v.exp_pv));
    if (v.chk_data) chk("vec_pop_data", 16'(pop_data), 16'(v.exp_data));
    chk("vec_err_ovf", 16'(err_ovf), 16'h0);
    chk("vec_err_udf", 16'(err_udf), 16'(v.exp_udf & ERR_EN));
  endtask

  // Reference model state for the hand-written sequences
  int         m_level;
  logic [5:0] m_wptr;
  logic [6:0] m_rptr;
  logic       m_ovf, m_udf;
  logic [7:0] exp_q[$];

  task automatic doCycle(input logic r, input logic p, input logic q, input logic [15:0] d);
    logic pa, qa;
    logic [7:0] b;
    b = 8'h00;
    @(negedge clk);
    rst_n = r; push = p; pop = q; push_data = d;
    #1;
    pa = r && p && (m_level <= 126);
    qa = r && q && (m_level != 0);
    chk("w_en", 16'(mem_w_en), 16'(pa));
    chk("w_port_en", 16'(mem_w_port_en), 16'(pa));
    chk("r_en", 16'(mem_r_port_en), 16'(qa));
    if (pa) begin
      chk("w_addr", 16'(mem_w_addr), 16'(m_wptr));
      chk("data_in", mem_data_in, d);
    end
    if (qa) chk("r_addr", 16'(mem_r_addr), 16'(m_rptr));
    if (!r) begin
      m_level = 0; m_wptr = '0; m_rptr = '0; m_ovf = 1'b0; m_udf = 1'b0;
      exp_q.delete();
    end else begin
      if (ERR_EN && p && m_level > 126) m_ovf = 1'b1;
      if (ERR_EN && q && m_level == 0)  m_udf = 1'b1;
      if (qa) begin b = exp_q.pop_front(); m_rptr = m_rptr + 7'd1; m_level = m_level - 1; end
      if (pa) begin exp_q.push_back(d[7:0]); exp_q.push_back(d[15:8]); m_wptr = m_wptr + 6'd1; m_level = m_level + 2; end
    end
    @(posedge clk);
    #1;
    chk("level", 16'(level), 16'(m_level));
    chk("empty", 16'(empty), 16'(m_level == 0));
    chk("full", 16'(full), 16'(m_level > 126));
    chk("pop_valid", 16'(pop_valid), 16'(qa));
    if (qa) chk("pop_data", 16'(pop_data), 16'(b));
    chk("err_ovf", 16'(err_ovf), 16'(m_ovf));
    chk("err_udf", 16'(err_udf), 16'(m_udf));
  endtask

  initial begin
    logic [7:0] dcnt;
    int n;
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; push_data = 16'h0;

    //            rst push pop data      wen ren lvl emp full pv chk data  udf
    vecs[0]  = '{1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b0, 8'd0, 1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b1,16'hFFFF, 1'b0,1'b0, 8'd0, 1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b0,16'h0000, 1'b0,1'b0, 8'd0, 1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0};
    vecs[3]  = '{1'b1,1'b1,1'b0,16'hBEEF, 1'b1,1'b0, 8'd2, 1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0};
    vecs[4]  = '{1'b1,1'b0,1'b1,16'h0000, 1'b0,1'b1, 8'd1, 1'b0,1'b0,1'b1,1'b1,8'hEF, 1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b1,16'h0000, 1'b0,1'b1, 8'd0, 1'b1,1'b0,1'b1,1'b1,8'hBE, 1'b0};
    vecs[6]  = '{1'b1,1'b0,1'b1,16'h0000, 1'b0,1'b0, 8'd0, 1'b1,1'b0,1'b0,1'b0,8'h00, 1'b1};
    vecs[7]  = '{1'b1,1'b1,1'b1,16'h1234, 1'b1,1'b0, 8'd2, 1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1};
    vecs[8]  = '{1'b1,1'b1,1'b1,16'h5678, 1'b1,1'b1, 8'd3, 1'b0,1'b0,1'b1,1'b1,8'h34, 1'b1};
    vecs[9]  = '{1'b1,1'b0,1'b1,16'h0000, 1'b0,1'b1, 8'd2, 1'b0,1'b0,1'b1,1'b1,8'h12, 1'b1};
    vecs[10] = '{1'b0,1'b1,1'b0,16'hAAAA, 1'b0,1'b0, 8'd0, 1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0};

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(vecs[i]);
    end

    // Fill to full, push while full, then exercise the 127/126 boundary
    doCycle(1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 64; i++) doCycle(1'b1, 1'b1, 1'b0, {8'(2*i+1), 8'(2*i)});
    chk("full_after_64", 16'(full), 16'h1);
    chk("level_after_64", 16'(level), 16'd128);
    doCycle(1'b1, 1'b1, 1'b0, 16'hDEAD);
    chk("err_ovf_when_full", 16'(err_ovf), 16'(ERR_EN));
    doCycle(1'b1, 1'b0, 1'b1, 16'h0);
    chk("full_at_127", 16'(full), 16'h1);
    doCycle(1'b1, 1'b0, 1'b1, 16'h0);
    doCycle(1'b1, 1'b1, 1'b1, 16'hC0DE);
    chk("level_push_pop_126", 16'(level), 16'd127);
    n = m_level;
    for (int i = 0; i < n; i++) doCycle(1'b1, 1'b0, 1'b1, 16'h0);
    chk("empty_after_drain", 16'(empty), 16'h1);

    // Three full fill/drain wraps with an incrementing byte pattern
    dcnt = 8'h00;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 64; i++) begin
        doCycle(1'b1, 1'b1, 1'b0, {dcnt + 8'd1, dcnt});
        dcnt = dcnt + 8'd2;
      end
      for (int i = 0; i < 128; i++) doCycle(1'b1, 1'b0, 1'b1, 16'h0);
    end

    // Streaming push and pop together, then reset mid-stream and pop on empty
    for (int i = 0; i < 20; i++) begin
      doCycle(1'b1, 1'b1, 1'b1, {dcnt + 8'd1, dcnt});
      dcnt = dcnt + 8'd2;
    end
    doCycle(1'b0, 1'b1, 1'b1, 16'h5555);
    chk("reset_level", 16'(level), 16'd0);
    chk("reset_pop_valid", 16'(pop_valid), 16'd0);
    doCycle(1'b1, 1'b0, 1'b1, 16'h0);
    chk("err_udf_pop_empty", 16'(err_udf), 16'(ERR_EN));
    doCycle(1'b1, 1'b0, 1'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
